// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter with burst limit; DM_ARB_RR_EN selects round-robin tie break
module dm_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_op,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_op,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_op,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          own_req;
    logic          oth_req;
    logic          tie_pick1;

    // Grants follow the owner's request combinationally so an owner can stream one beat per cycle.
    assign m0_gnt = (state == OWN0) && m0_req;
    assign m1_gnt = (state == OWN1) && m1_req;

    assign own_req = (state == OWN1) ? m1_req : m0_req;
    assign oth_req = (state == OWN1) ? m0_req : m1_req;
    assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;

`ifdef DM_ARB_RR_EN
    logic last_served;  // 1 = port 1 served most recently

    assign tie_pick1 = ~last_served;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_served <= 1'b1;
        end else if (m0_gnt) begin
            last_served <= 1'b0;
        end else if (m1_gnt) begin
            last_served <= 1'b1;
        end
    end
`else
    assign tie_pick1 = 1'b0;
`endif

    always_comb begin
        dm_w     = 1'b0;
        dm_r     = 1'b0;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;
        dm_op    = 3'd0;
        if (m0_gnt) begin
            dm_w     = m0_we;
            dm_r     = ~m0_we;
            dm_addr  = m0_addr;
            dm_wdata = m0_wdata;
            dm_op    = m0_op;
        end else if (m1_gnt) begin
            dm_w     = m1_we;
            dm_r     = ~m1_we;
            dm_addr  = m1_addr;
            dm_wdata = m1_wdata;
            dm_op    = m1_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m0_req && m1_req) begin
                        state <= tie_pick1 ? OWN1 : OWN0;
                    end else if (m0_req) begin
                        state <= OWN0;
                    end else if (m1_req) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (own_req) begin
                        // Hand over without an idle bubble once the owner has used its burst.
                        if (oth_req && (cnt_inc == MAX_CNT)) begin
                            state <= (state == OWN0) ? OWN1 : OWN0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                        if (oth_req) begin
                            state <= (state == OWN0) ? OWN1 : OWN0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Load data is captured at the accepting edge; reset drops any load still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= dm_rdata;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter (MAX_BURST=4)
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_op, m1_op;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dm_w, dm_r;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_op;

    logic [31:0] mem [0:63];
    int          n_cmp = 0;
    int          n_err = 0;

    dm_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_op(m0_op),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_op(m1_op),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (dm_w) mem[dm_addr[7:2]] <= dm_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_op = 0;
        m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_op = 0;
        do_reset();
        settle();
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_strobes", {dm_w, dm_r}, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_dm_addr", dm_addr, 0);

        // single load from m0
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_op = 3'b010;
        settle();
        chk("t1_idle_gnt", m0_gnt, 0);
        chk("t1_idle_dm_r", dm_r, 0);
        tick(); settle();
        chk("t1_m0_gnt", m0_gnt, 1);
        chk("t1_dm_r", dm_r, 1);
        chk("t1_dm_addr", dm_addr, 32'h10);
        chk("t1_dm_op", dm_op, 3'b010);
        chk("t1_m1_gnt", m1_gnt, 0);
        tick();
        m0_req = 0;
        settle();
        chk("t1_rvalid", m0_rvalid, 1);
        chk("t1_rdata", m0_rdata, 32'hA000_0004);
        chk("t1_gnt_drop", m0_gnt, 0);
        tick(); settle();
        chk("t1_rvalid_low", m0_rvalid, 0);
        chk("t1_rdata_hold", m0_rdata, 32'hA000_0004);

        // simultaneous requests from reset, handover without idle
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h1111_1111;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_op = 3'b001;
        tick(); settle();
        chk("t2_m0_first", {m0_gnt, m1_gnt}, 2'b10);
        chk("t2_dm_w", {dm_w, dm_r}, 2'b10);
        tick();
        m0_req = 0;
        settle();
        chk("t2_gap", {m0_gnt, m1_gnt}, 2'b00);
        tick(); settle();
        chk("t2_m1_next", {m0_gnt, m1_gnt}, 2'b01);
        chk("t2_m1_addr", dm_addr, 32'h10);
        chk("t2_m1_op", dm_op, 3'b001);
        tick();
        m1_req = 0;
        settle();
        chk("t2_m1_rvalid", m1_rvalid, 1);
        chk("t2_m1_rdata", m1_rdata, 32'hA000_0004);
        chk("t2_mem_store", mem[12], 32'h1111_1111);
        tick();

        // burst alternation with both ports streaming stores
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'h0000_00A0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h44; m1_wdata = 32'h0000_00B1;
        settle();
        chk("t3_idle", {m0_gnt, m1_gnt}, 2'b00);
        for (int i = 0; i < 16; i++) begin
            tick(); settle();
            chk($sformatf("t3_beat%0d", i), {m0_gnt, m1_gnt}, ((i / 4) % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("t3_strobe%0d", i), {dm_w, dm_r}, 2'b10);
        end
        m0_req = 0; m1_req = 0;
        tick(); tick();

        // repeated ties through IDLE
        do_reset();
        m0_we = 0; m1_we = 0; m0_addr = 32'h08; m1_addr = 32'h0C;
        for (int k = 0; k < 4; k++) begin
            m0_req = 1; m1_req = 1;
            tick(); settle();
`ifdef DM_ARB_RR_EN
            chk($sformatf("t4_tie%0d", k), {m0_gnt, m1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
`else
            chk($sformatf("t4_tie%0d", k), {m0_gnt, m1_gnt}, 2'b10);
`endif
            tick();
            m0_req = 0; m1_req = 0;
            tick();
        end

        // store on m1 then load back on m0
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEAD_BEEF; m1_op = 3'b010;
        tick(); settle();
        chk("t5_m1_gnt", m1_gnt, 1);
        chk("t5_dm_wdata", dm_wdata, 32'hDEAD_BEEF);
        chk("t5_dm_w", {dm_w, dm_r}, 2'b10);
        tick();
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        settle();
        chk("t5_no_m1_rvalid_a", m1_rvalid, 0);
        tick(); settle();
        chk("t5_m0_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 0;
        settle();
        chk("t5_m0_rvalid", m0_rvalid, 1);
        chk("t5_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t5_no_m1_rvalid_b", m1_rvalid, 0);
        tick();

        // reset right after an accepted load
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        tick(); settle();
        chk("t6_gnt", m0_gnt, 1);
        tick();
        rst = 1; m0_req = 0;
        settle();
        chk("t6_rvalid_rst", m0_rvalid, 0);
        chk("t6_rdata_rst", m0_rdata, 0);
        tick();
        rst = 0;
        tick(); settle();
        chk("t6_rvalid_after", m0_rvalid, 0);
        chk("t6_idle", {m0_gnt, m1_gnt}, 2'b00);
        m0_req = 1; m1_req = 1;
        tick(); settle();
        chk("t6_tie_port0", {m0_gnt, m1_gnt}, 2'b10);
        m0_req = 0; m1_req = 0;
        tick(); tick();

        // saturated counter holds while the other port is idle
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h50; m0_wdata = 32'h5;
        m1_we = 1; m1_addr = 32'h54;
        tick();
        for (int i = 0; i < 6; i++) begin
            settle();
            chk($sformatf("t7_solo%0d", i), {m0_gnt, m1_gnt}, 2'b10);
            tick();
        end
        m1_req = 1;
        settle();
        chk("t7_last_m0", {m0_gnt, m1_gnt}, 2'b10);
        tick(); settle();
        chk("t7_switch", {m0_gnt, m1_gnt}, 2'b01);
        m0_req = 0; m1_req = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, max consecutive accepted beats for one owner while the other port requests; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mN_req  input  1  port N (N in {0,1}) access request; held with its payload until mN_gnt.
REQ-005 mN_we  input  1  port N: 1 = store, 0 = load.
REQ-006 mN_addr  input  32  port N byte address.
REQ-007 mN_wdata  input  32  port N store data.
REQ-008 mN_op  input  3  port N data-memory op code (byte/half/word, sign/zero), passed through unmodified.
REQ-009 mN_gnt  output  1  port N access accepted this cycle.
REQ-010 mN_rvalid  output  1  port N load data valid, one cycle.
REQ-011 mN_rdata  output  32  port N registered load data.
REQ-012 dm_w / dm_r  output  1 each  data-memory write / read strobes.
REQ-013 dm_addr, dm_wdata  output  32 each; dm_op  output  3  data-memory payload.
REQ-014 dm_rdata  input  32  data-memory combinational read data.

Function
REQ-015 States: IDLE, OWN0, OWN1; owner register and beat counter (width ceil(log2(MAX_BURST+1))) update only on posedge clk.
REQ-016 IDLE: no grants; dm_w=dm_r=0; dm_addr/dm_wdata=0, dm_op=0.
REQ-017 IDLE, exactly one mN_req high -> OWNN next cycle; both high -> tie rule (REQ-027/028); none -> stay IDLE.
REQ-018 OWNN with mN_req=1: mN_gnt=1 combinationally; dm payload = port N fields; dm_w=mN_we, dm_r=~mN_we; other port gnt=0.
REQ-019 OWNN with mN_req=0: no grant, strobes 0; next state OWN(other) if other req, else IDLE; counter cleared.
REQ-020 Each accepted beat increments the counter; counter saturates at MAX_BURST.
REQ-021 OWNN, accepted beat brings counter to MAX_BURST while other port requests -> next state OWN(other), counter 0, no IDLE bubble.
REQ-022 Counter at MAX_BURST with other port idle -> stay OWNN, counter held; switch on first cycle other port requests.
REQ-023 Arbitration latency: request in IDLE sees gnt earliest one cycle later; back-to-back beats from owner at 1 per cycle.
REQ-024 Accepted load: next cycle mN_rvalid=1, mN_rdata = dm_rdata captured at the accepting edge; rvalid low otherwise; mN_rdata holds last value.
REQ-025 Never both gnt high; never dm_w and dm_r both high.

Reset
REQ-026 rst high: state IDLE, counter 0, last-served = port 1, mN_rvalid=0, mN_rdata=0, all gnt/strobes 0; in-flight load discarded, no rvalid after release.

Configuration
REQ-027 Macro DM_ARB_RR_EN defined: IDLE ties go to port not last served (port 0 first after reset).
REQ-028 DM_ARB_RR_EN undefined: IDLE ties always go to port 0; burst-limit switching (REQ-021) retained in both builds.

Verification
REQ-029 m0 load addr 0x10 alone from reset -> IDLE, cycle+1 m0_gnt, dm_r=1, dm_addr=0x10; cycle+2 m0_rvalid with stored word.
REQ-030 m0 and m1 both request from reset -> m0 granted first; after m0 drops, m1 granted next cycle with no IDLE cycle.
REQ-031 m0 continuous 8 stores, m1 requesting, MAX_BURST=4 -> m0 gets 4 gnts, m1 gets 4, alternation repeats.
REQ-032 RR build, repeated simultaneous single-beat requests through IDLE -> grants alternate 0,1,0,1; non-RR build -> port 0 wins every tie.
REQ-033 m1 store 0xDEADBEEF to 0x20 then m0 load 0x20 -> m0_rdata=0xDEADBEEF, m1_rvalid never set.
REQ-034 rst asserted the cycle after a granted load -> no rvalid, state IDLE, next tie goes to port 0.
